// File: rtl/alu_stage_pkg.sv
// Shared ALU-stage definitions: ALU operation encoding and the operand bypass select.
package alu_stage_pkg;

    localparam int ALUCONT_W = 4;

    // ALU op index is {alucont[3], alucont[1:0]}; alucont[2] turns ADD/SLT into subtract.
    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SLT = 3'b011;
    localparam logic [2:0] ALU_OP_XOR = 3'b100;
    localparam int         ALUCONT_SUB_BIT = 2;

    localparam logic [ALUCONT_W-1:0] ALUCONT_AND = 4'b0000;
    localparam logic [ALUCONT_W-1:0] ALUCONT_OR  = 4'b0001;
    localparam logic [ALUCONT_W-1:0] ALUCONT_ADD = 4'b0010;
    localparam logic [ALUCONT_W-1:0] ALUCONT_SUB = 4'b0110;
    localparam logic [ALUCONT_W-1:0] ALUCONT_SLT = 4'b0111;
    localparam logic [ALUCONT_W-1:0] ALUCONT_XOR = 4'b1000;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_MEM,
        FWD_WB
    } fwd_sel_e;

    function automatic logic [2:0] alu_op_index(input logic [ALUCONT_W-1:0] alucont);
        return {alucont[3], alucont[1:0]};
    endfunction

    function automatic logic alu_is_sub(input logic [ALUCONT_W-1:0] alucont);
        return alucont[ALUCONT_SUB_BIT];
    endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// Operand bypass for one source register: MEM beats WB beats the stored value,
// and register x0 always reads as zero.
module alu_fwd_mux
    import alu_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] reg_data,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_regwrite,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_regwrite,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] data
);

    logic     rs_zero;
    logic     mem_hit;
    logic     wb_hit;
    fwd_sel_e sel;

    always_comb begin
        rs_zero = (rs == '0);
        mem_hit = mem_regwrite && (mem_rd == rs) && (mem_rd != '0);
        wb_hit  = wb_regwrite && (wb_rd == rs) && (wb_rd != '0);

        sel = FWD_REG;
        if (mem_hit)
            sel = FWD_MEM;
        else if (wb_hit)
            sel = FWD_WB;

        data = reg_data;
        case (sel)
            FWD_MEM: data = mem_result;
            FWD_WB:  data = wb_result;
            default: data = reg_data;
        endcase
        if (rs_zero)
            data = '0;
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID->EX register feeding the ALU, with MEM/WB bypass and load-use stall.
// Optional counters: define ALU_OPERAND_STAGE_PERF_EN for perf_stall_cycles / perf_bubbles.
module alu_operand_stage
    import alu_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
`ifdef ALU_OPERAND_STAGE_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [RA_W-1:0]      id_rs1,
    input  logic [RA_W-1:0]      id_rs2,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic                 id_alusrc,
    input  logic [ALUCONT_W-1:0] id_alucont,
    input  logic                 id_sltunsigned,
    input  logic [RA_W-1:0]      id_rd,
    input  logic                 id_regwrite,
    input  logic                 id_memread,
    input  logic                 flush,
    input  logic                 ex_ready,
    output logic                 ex_valid,
    output logic [XLEN-1:0]      ex_a,
    output logic [XLEN-1:0]      ex_b,
    output logic [ALUCONT_W-1:0] ex_alucont,
    output logic                 ex_sltunsigned,
    output logic [RA_W-1:0]      ex_rd,
    output logic                 ex_regwrite,
    output logic                 ex_memread,
    input  logic [RA_W-1:0]      mem_rd,
    input  logic                 mem_regwrite,
    input  logic [XLEN-1:0]      mem_result,
    input  logic [RA_W-1:0]      wb_rd,
    input  logic                 wb_regwrite,
    input  logic [XLEN-1:0]      wb_result
`ifdef ALU_OPERAND_STAGE_PERF_EN
    ,
    output logic [PERF_W-1:0]    perf_stall_cycles,
    output logic [PERF_W-1:0]    perf_bubbles
`endif
);

    logic                 vld_p1;
    logic [RA_W-1:0]      rs1_p1;
    logic [RA_W-1:0]      rs2_p1;
    logic [XLEN-1:0]      rs1_data_p1;
    logic [XLEN-1:0]      rs2_data_p1;
    logic [XLEN-1:0]      imm_p1;
    logic                 alusrc_p1;
    logic [ALUCONT_W-1:0] alucont_p1;
    logic                 sltunsigned_p1;
    logic [RA_W-1:0]      rd_p1;
    logic                 regwrite_p1;
    logic                 memread_p1;

    logic                 hazard;
    logic                 xfer;
    logic                 hold;
    logic [XLEN-1:0]      rs2_fwd;

    // WB write-through: a register being written back this cycle wins over the stale value.
    function automatic logic [XLEN-1:0] wb_pick(
        input logic [RA_W-1:0] rs,
        input logic [XLEN-1:0] cur,
        input logic            wen,
        input logic [RA_W-1:0] wrd,
        input logic [XLEN-1:0] wdata
    );
        return (wen && (wrd == rs) && (wrd != '0)) ? wdata : cur;
    endfunction

    always_comb begin
        hazard   = vld_p1 && memread_p1 && (rd_p1 != '0) &&
                   ((rd_p1 == id_rs1) || (!id_alusrc && (rd_p1 == id_rs2)));
        id_ready = !hazard && (!vld_p1 || ex_ready);
        xfer     = id_valid && id_ready && !flush;
        hold     = vld_p1 && !ex_ready;
    end

    // ID -> EX boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1         <= 1'b0;
            rs1_p1         <= '0;
            rs2_p1         <= '0;
            rs1_data_p1    <= '0;
            rs2_data_p1    <= '0;
            imm_p1         <= '0;
            alusrc_p1      <= 1'b0;
            alucont_p1     <= '0;
            sltunsigned_p1 <= 1'b0;
            rd_p1          <= '0;
            regwrite_p1    <= 1'b0;
            memread_p1     <= 1'b0;
        end else if (flush) begin
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
            memread_p1  <= 1'b0;
        end else if (xfer) begin
            vld_p1         <= 1'b1;
            rs1_p1         <= id_rs1;
            rs2_p1         <= id_rs2;
            rs1_data_p1    <= wb_pick(id_rs1, id_rs1_data, wb_regwrite, wb_rd, wb_result);
            rs2_data_p1    <= wb_pick(id_rs2, id_rs2_data, wb_regwrite, wb_rd, wb_result);
            imm_p1         <= id_imm;
            alusrc_p1      <= id_alusrc;
            alucont_p1     <= id_alucont;
            sltunsigned_p1 <= id_sltunsigned;
            rd_p1          <= id_rd;
            regwrite_p1    <= id_regwrite;
            memread_p1     <= id_memread;
        end else if (hold) begin
            // A stalled instruction keeps absorbing WB results so the bypass outlives its producer.
            rs1_data_p1 <= wb_pick(rs1_p1, rs1_data_p1, wb_regwrite, wb_rd, wb_result);
            rs2_data_p1 <= wb_pick(rs2_p1, rs2_data_p1, wb_regwrite, wb_rd, wb_result);
        end else begin
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
            memread_p1  <= 1'b0;
        end
    end

    alu_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .rs           (rs1_p1),
        .reg_data     (rs1_data_p1),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .mem_result   (mem_result),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .wb_result    (wb_result),
        .data         (ex_a)
    );

    alu_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .rs           (rs2_p1),
        .reg_data     (rs2_data_p1),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .mem_result   (mem_result),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .wb_result    (wb_result),
        .data         (rs2_fwd)
    );

    always_comb begin
        ex_b           = alusrc_p1 ? imm_p1 : rs2_fwd;
        ex_valid       = vld_p1;
        ex_alucont     = alucont_p1;
        ex_sltunsigned = sltunsigned_p1;
        ex_rd          = rd_p1;
        ex_regwrite    = regwrite_p1;
        ex_memread     = memread_p1;
    end

`ifdef ALU_OPERAND_STAGE_PERF_EN
    logic vld_nxt;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        vld_nxt = !flush && (xfer || hold);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_bubbles      <= '0;
        end else begin
            if (hazard && id_valid)
                perf_stall_cycles <= sat_inc(perf_stall_cycles);
            if (!vld_nxt)
                perf_bubbles <= sat_inc(perf_bubbles);
        end
    end
`endif

endmodule
